bit_serial_gate_unit: RTL and testbench

//   Sequencer for the mux-realised gate datapath. It accepts an opcode and two WIDTH-bit operands

---
 rtl/gate_mux_pkg.sv | 53 +++++
 rtl/mux_2to1.sv | 12 +
 rtl/bit_serial_gate_unit.sv | 89 ++++++++
 tb/tb_bit_serial_gate_unit.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_mux_pkg.sv
// gate_mux_pkg: opcodes, FSM state encoding and mux-input selection shared by the gate unit
//   OP_AND..OP_XNOR  legal opcodes (6/7 illegal)
//   state_t          one-hot FSM states
//   src_t/mux_sel_t  per-op source of mux inputs d0/d1
package gate_mux_pkg;
    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_NAND = 3'd2;
    localparam logic [2:0] OP_NOR  = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE = 3'b001,
        ST_RUN  = 3'b010,
        ST_DONE = 3'b100
    } state_t;

    typedef enum logic [1:0] {
        SRC_ZERO = 2'd0,
        SRC_ONE  = 2'd1,
        SRC_B    = 2'd2,
        SRC_NB   = 2'd3
    } src_t;

    typedef struct packed {
        src_t d0;
        src_t d1;
    } mux_sel_t;

    function automatic logic op_legal(input logic [2:0] op);
        return op <= OP_XNOR;
    endfunction

    // Each gate is realised as y = a ? d1 : d0 with d0/d1 drawn from {0, 1, b, ~b}
    function automatic mux_sel_t op_sel(input logic [2:0] op);
        case (op)
            OP_AND:  return '{d0: SRC_ZERO, d1: SRC_B};
            OP_OR:   return '{d0: SRC_B,    d1: SRC_ONE};
            OP_NAND: return '{d0: SRC_ONE,  d1: SRC_NB};
            OP_NOR:  return '{d0: SRC_NB,   d1: SRC_ZERO};
            OP_XOR:  return '{d0: SRC_B,    d1: SRC_NB};
            OP_XNOR: return '{d0: SRC_NB,   d1: SRC_B};
            default: return '{d0: SRC_ZERO, d1: SRC_ZERO};
        endcase
    endfunction

    function automatic logic src_val(input src_t src, input logic b_bit);
        return src == SRC_ZERO ? 1'b0 :
               src == SRC_ONE  ? 1'b1 :
               src == SRC_B    ? b_bit : ~b_bit;
    endfunction
endpackage

// File: rtl/mux_2to1.sv
// mux_2to1: single-bit 2:1 multiplexer cell
//   d0, d1  data inputs
//   s       select (0 -> d0, 1 -> d1)
//   y       output
module mux_2to1 (
    input  logic d0,
    input  logic d1,
    input  logic s,
    output logic y
);
    assign y = s ? d1 : d0;
endmodule

// File: rtl/bit_serial_gate_unit.sv
// bit_serial_gate_unit: evaluates a bitwise gate op one bit per cycle through one shared mux
//   clk, rst               clock, async active-high reset
//   in_valid/in_ready      request handshake carrying op, a, b
//   out_valid/out_ready    result handshake carrying result, err
//   busy                   unit not idle
module bit_serial_gate_unit
    import gate_mux_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             err,
    output logic             busy
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state, state_next;
    logic [CW-1:0]    cnt;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q;
    mux_sel_t         sel;
    logic             accept, d0, d1, s, y;

    assign in_ready  = state == ST_IDLE;
    assign out_valid = state == ST_DONE;
    assign busy      = state != ST_IDLE;
    assign accept    = in_valid & in_ready;

    always_comb begin
        sel = op_sel(op_q);
        s   = a_q[cnt];
        d0  = src_val(sel.d0, b_q[cnt]);
        d1  = src_val(sel.d1, b_q[cnt]);
    end

    mux_2to1 u_mux (
        .d0(d0),
        .d1(d1),
        .s (s),
        .y (y)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: state_next = accept ? (op_legal(op) ? ST_RUN : ST_DONE) : ST_IDLE;
            ST_RUN:  state_next = cnt == LAST ? ST_DONE : ST_RUN;
            ST_DONE: state_next = out_ready ? ST_IDLE : ST_DONE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Counter saturates at LAST; it is only meaningful in RUN and is cleared on accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            result <= '0;
            err    <= 1'b0;
        end else if (accept) begin
            cnt    <= '0;
            op_q   <= op;
            a_q    <= a;
            b_q    <= b;
            result <= '0;
            err    <= ~op_legal(op);
        end else if (state == ST_RUN) begin
            result[cnt] <= y;
            cnt         <= cnt == LAST ? cnt : cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_bit_serial_gate_unit.sv
module tb_bit_serial_gate_unit;
    parameter int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst, in_valid, out_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] a, b, result;
    logic             in_ready, out_valid, err, busy;
    int               n_checks = 0;
    int               n_fail = 0;

    always #5 clk = ~clk;

    bit_serial_gate_unit #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .err(err), .busy(busy)
    );

    function automatic logic [WIDTH-1:0] ref_gate(input logic [2:0] o, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        case (o)
            3'd0: return x & y;
            3'd1: return x | y;
            3'd2: return ~(x & y);
            3'd3: return ~(x | y);
            3'd4: return x ^ y;
            3'd5: return ~(x ^ y);
            default: return '0;
        endcase
    endfunction

    task automatic send(input logic [2:0] o, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        @(negedge clk);
        in_valid = 1'b1;
        op = o;
        a = x;
        b = y;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op = 3'($urandom);
        a = WIDTH'($urandom);
        b = WIDTH'($urandom);
    endtask

    task automatic wait_out(output int cyc);
        cyc = 1;
        while (out_valid !== 1'b1 && cyc < 4 * WIDTH + 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic release_out;
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({in_ready, out_valid, busy, err} !== 4'b1000) begin
            n_fail++; $display("FAIL reset_flags: got %b want 1000", {in_ready, out_valid, busy, err});
        end
        n_checks++;
        if (result !== '0) begin n_fail++; $display("FAIL reset_result: got %h want 0", result); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_and_latency;
        int cyc;
        logic [WIDTH-1:0] x = WIDTH'(8'hF0), y = WIDTH'(8'hCC);
        send(3'd0, x, y);
        n_checks++;
        if ({in_ready, busy} !== 2'b01) begin n_fail++; $display("FAIL and_busy: got %b want 01", {in_ready, busy}); end
        wait_out(cyc);
        n_checks++;
        if (cyc != WIDTH + 1) begin n_fail++; $display("FAIL and_latency: got %0d want %0d", cyc, WIDTH + 1); end
        n_checks++;
        if ({result, err} !== {ref_gate(3'd0, x, y), 1'b0}) begin
            n_fail++; $display("FAIL and_result: got %h/%b want %h/0", result, err, ref_gate(3'd0, x, y));
        end
        release_out;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL and_idle: got %b want 1", in_ready); end
    endtask

    task automatic test_back_to_back;
        int cyc;
        logic [WIDTH-1:0] x = WIDTH'(8'hA5), y = WIDTH'(8'h3C);
        for (int o = 0; o < 6; o++) begin
            send(3'(o), x, y);
            cyc = 1;
            while (out_valid !== 1'b1 && cyc < 4 * WIDTH + 20) begin
                n_checks++;
                if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_in_ready op%0d: got %b want 0", o, in_ready); end
                @(posedge clk);
                #1;
                cyc++;
            end
            n_checks++;
            if (cyc != WIDTH + 1) begin n_fail++; $display("FAIL b2b_latency op%0d: got %0d want %0d", o, cyc, WIDTH + 1); end
            n_checks++;
            if ({result, err} !== {ref_gate(3'(o), x, y), 1'b0}) begin
                n_fail++; $display("FAIL b2b_result op%0d: got %h/%b want %h/0", o, result, err, ref_gate(3'(o), x, y));
            end
            release_out;
            n_checks++;
            if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_idle op%0d: got %b want 1", o, in_ready); end
        end
    endtask

    task automatic test_backpressure;
        int cyc;
        logic [2:0] o = 3'($urandom_range(0, 5));
        logic [WIDTH-1:0] x = WIDTH'($urandom), y = WIDTH'($urandom);
        send(o, x, y);
        wait_out(cyc);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            op = 3'($urandom);
            a = WIDTH'($urandom);
            b = WIDTH'($urandom);
            @(posedge clk);
            #1;
            n_checks++;
            if ({out_valid, in_ready, result} !== {2'b10, ref_gate(o, x, y)}) begin
                n_fail++; $display("FAIL bp_hold cyc%0d: got %b%b/%h want 10/%h", i, out_valid, in_ready, result, ref_gate(o, x, y));
            end
        end
        in_valid = 1'b0;
        release_out;
        n_checks++;
        if ({in_ready, out_valid, busy} !== 3'b100) begin
            n_fail++; $display("FAIL bp_release: got %b want 100", {in_ready, out_valid, busy});
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL bp_no_accept: got %b want 0", busy); end
    endtask

    task automatic test_illegal;
        int cyc;
        send(3'd6, WIDTH'($urandom), WIDTH'($urandom));
        wait_out(cyc);
        n_checks++;
        if (cyc != 1) begin n_fail++; $display("FAIL ill_latency: got %0d want 1", cyc); end
        n_checks++;
        if ({result, err} !== {{WIDTH{1'b0}}, 1'b1}) begin n_fail++; $display("FAIL ill_result: got %h/%b want 0/1", result, err); end
        release_out;
        send(3'd1, '0, WIDTH'(1));
        wait_out(cyc);
        n_checks++;
        if ({result, err, cyc} !== {ref_gate(3'd1, '0, WIDTH'(1)), 1'b0, WIDTH + 1}) begin
            n_fail++; $display("FAIL ill_next: got %h/%b/%0d want %h/0/%0d", result, err, cyc, ref_gate(3'd1, '0, WIDTH'(1)), WIDTH + 1);
        end
        release_out;
    endtask

    task automatic test_reset_mid_run;
        int cyc;
        logic [WIDTH-1:0] x = '1, y = WIDTH'(8'h0F);
        send(3'd4, WIDTH'($urandom), WIDTH'($urandom));
        repeat (4) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({in_ready, out_valid, busy, err} !== 4'b1000) begin
            n_fail++; $display("FAIL rst_run_flags: got %b want 1000", {in_ready, out_valid, busy, err});
        end
        n_checks++;
        if (result !== '0) begin n_fail++; $display("FAIL rst_run_result: got %h want 0", result); end
        @(negedge clk);
        rst = 1'b0;
        send(3'd4, x, y);
        wait_out(cyc);
        n_checks++;
        if ({result, err, cyc} !== {ref_gate(3'd4, x, y), 1'b0, WIDTH + 1}) begin
            n_fail++; $display("FAIL rst_run_next: got %h/%b/%0d want %h/0/%0d", result, err, cyc, ref_gate(3'd4, x, y), WIDTH + 1);
        end
        release_out;
    endtask

    task automatic test_random;
        int cyc, want_cyc;
        logic [2:0] o;
        logic [WIDTH-1:0] x, y;
        logic hold;
        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom_range(0, 7));
            x = WIDTH'($urandom);
            y = WIDTH'($urandom);
            hold = 1'($urandom);
            out_ready = hold;
            send(o, x, y);
            wait_out(cyc);
            want_cyc = o > 3'd5 ? 1 : WIDTH + 1;
            n_checks++;
            if ({result, err, cyc} !== {ref_gate(o, x, y), o > 3'd5, want_cyc}) begin
                n_fail++; $display("FAIL rand%0d op%0d: got %h/%b/%0d want %h/%b/%0d", i, o, result, err, cyc, ref_gate(o, x, y), o > 3'd5, want_cyc);
            end
            if (hold) begin
                @(posedge clk);
                #1;
                out_ready = 1'b0;
                n_checks++;
                if ({out_valid, in_ready} !== 2'b01) begin
                    n_fail++; $display("FAIL rand%0d single_done: got %b want 01", i, {out_valid, in_ready});
                end
            end else begin
                repeat ($urandom_range(0, 3)) @(posedge clk);
                release_out;
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset;
        test_and_latency;
        test_back_to_back;
        test_backpressure;
        test_illegal;
        test_reset_mid_run;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
